// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: default payload width, beat record and
// the occupancy states of the register slice.
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

endpackage

// File: rtl/streamer_up.sv
// Counting stream source: emits 0 .. count_up_to-1 then wraps, marking the
// final value with count_last; advances only on a valid/ready handshake.
module streamer_up
  import axis_pkg::*;
#(
  parameter int DataWidth = AXIS_DATA_WIDTH
) (
  input  logic                 counter_clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] count_up_to,
  output logic [DataWidth-1:0] count_up,
  output logic                 count_valid,
  input  logic                 count_ready,
  output logic                 count_last
);

  assign count_last = count_valid && (count_up == count_up_to - DataWidth'(1));

  always_ff @(posedge counter_clk or negedge reset) begin
    if (!reset) begin
      count_up    <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b1;
      if (count_valid && count_ready) begin
        count_up <= count_last ? '0 : count_up + DataWidth'(1);
      end
    end
  end

endmodule

// File: rtl/axis_register_st.sv
// Single-stage AXI4-Stream skid buffer: every output (tdata, tlast, tvalid and
// the upstream tready) comes straight from a flop.
module axis_register_st
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } slot_t;

  slice_state_t state;
  slot_t        main_q;
  slot_t        skid_q;
  slot_t        in_beat;
  logic         in_acc;
  logic         out_acc;

  assign in_beat      = '{data: s_axis_tdata, last: s_axis_tlast};
  assign in_acc       = s_axis_tvalid & s_axis_tready;
  assign out_acc      = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata = main_q.data;
  assign m_axis_tlast = main_q.last;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the order of the statements below cannot change the hardware.
  // The payload registers are cleared on reset too, because the downstream
  // side must see tdata=0 and tlast=0 while the slice is held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          // tready is held low through reset and opens on the first edge after it
          s_axis_tready <= 1'b1;
          if (in_acc) begin
            main_q        <= in_beat;
            m_axis_tvalid <= 1'b1;
            state         <= ONE;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            main_q <= in_beat;
          end else if (in_acc) begin
            skid_q        <= in_beat;
            s_axis_tready <= 1'b0;
            state         <= FULL;
          end else if (out_acc) begin
            m_axis_tvalid <= 1'b0;
            state         <= EMPTY;
          end
        end
        FULL: begin
          if (out_acc) begin
            main_q        <= skid_q;
            s_axis_tready <= 1'b1;
            state         <= ONE;
          end
        end
        default: begin
          state         <= EMPTY;
          m_axis_tvalid <= 1'b0;
          s_axis_tready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_register_st.sv
// Bench for axis_register_st driven by streamer_up; a scoreboard queue holds
// the beats the slice has accepted and checks each one as it leaves.
module tb_axis_register_st;
  import axis_pkg::*;

  localparam int DW     = AXIS_DATA_WIDTH;
  localparam int PKT    = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          src_valid;
  logic          src_en;
  logic [DW-1:0] count_up_to;

  int     pass_cnt;
  int     total_cnt;
  int     delivered;
  beat_t  sb_q[$];
  int     model_val;
  logic   seen_edge;

  axis_register_st #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  logic src_ready;
  assign s_axis_tvalid = src_valid & src_en;
  assign src_ready     = s_axis_tready & src_en;

  streamer_up #(.DataWidth(DW)) src (
    .counter_clk(clk),
    .reset      (rst_n),
    .count_up_to(count_up_to),
    .count_up   (s_axis_tdata),
    .count_valid(src_valid),
    .count_ready(src_ready),
    .count_last (s_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice's tready may only be high once a clock edge has been seen out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_edge <= 1'b0;
    else        seen_edge <= 1'b1;
  end

  // Monitor: at the falling edge, inputs and outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      beat_t exp_b;
      logic  exp_ready;
      exp_ready = seen_edge && (sb_q.size() < 2);
      total_cnt++;
      if (s_axis_tready !== exp_ready) $display("FAIL s_tready: got %b expected %b (occ %0d)", s_axis_tready, exp_ready, sb_q.size());
      else pass_cnt++;
      total_cnt++;
      if (m_axis_tvalid !== (sb_q.size() > 0)) $display("FAIL m_tvalid: got %b expected %b", m_axis_tvalid, sb_q.size() > 0);
      else pass_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_underflow: got beat %0d with no expected beat", m_axis_tdata);
        end else begin
          exp_b = sb_q.pop_front();
          if (m_axis_tdata !== exp_b.data || m_axis_tlast !== exp_b.last)
            $display("FAIL sb_beat: got data %0d last %b expected data %0d last %b", m_axis_tdata, m_axis_tlast, exp_b.data, exp_b.last);
          else pass_cnt++;
        end
        delivered++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        total_cnt++;
        if (s_axis_tdata !== DW'(model_val)) $display("FAIL src_data: got %0d expected %0d", s_axis_tdata, model_val);
        else pass_cnt++;
        sb_q.push_back('{data: DW'(model_val), last: (model_val == PKT - 1)});
        model_val = (model_val == PKT - 1) ? 0 : model_val + 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    src_en        = 1'b0;
    m_axis_tready = 1'b1;
    count_up_to   = DW'(PKT);
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0)
      $display("FAIL reset_vals: got tvalid %b tready %b tdata %0d tlast %b expected 0 0 0 0", m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tlast);
    else pass_cnt++;
    #5 rst_n = 1'b1;
    #1;
    total_cnt++;
    if (s_axis_tready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", s_axis_tready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL ready_after_edge: got %b expected 1", s_axis_tready);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    int start;
    src_en        = 1'b1;
    m_axis_tready = 1'b1;
    tick(3);
    start = delivered;
    tick(32);
    total_cnt++;
    if (delivered - start !== 32) $display("FAIL throughput: got %0d beats expected 32", delivered - start);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    m_axis_tready = 1'b0;
    held = m_axis_tdata;
    tick(4);
    total_cnt++;
    if (s_axis_tready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", s_axis_tready);
    else pass_cnt++;
    total_cnt++;
    if (m_axis_tdata !== held) $display("FAIL bp_hold: got %0d expected %0d", m_axis_tdata, held);
    else pass_cnt++;
    m_axis_tready = 1'b1;
    tick(10);
  endtask

  task automatic test_valid_gaps();
    src_en = 1'b0;
    tick(4);
    total_cnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL gap_valid: got %b expected 0", m_axis_tvalid);
    else pass_cnt++;
    src_en = 1'b1;
    tick(10);
  endtask

  task automatic test_combined();
    for (int c = 0; c < 90; c++) begin
      src_en        = ((c / 3) % 3) != 0;
      m_axis_tready = ((c / 5) % 4) != 1;
      tick();
    end
    src_en        = 1'b0;
    m_axis_tready = 1'b1;
    tick(4);
    total_cnt++;
    if (sb_q.size() !== 0 || m_axis_tvalid !== 1'b0)
      $display("FAIL drain: got occ %0d tvalid %b expected 0 0", sb_q.size(), m_axis_tvalid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    src_en        = 1'b1;
    m_axis_tready = 1'b0;
    tick(3);
    total_cnt++;
    if (sb_q.size() !== 2 || m_axis_tvalid !== 1'b1) $display("FAIL mid_full: got occ %0d tvalid %b expected 2 1", sb_q.size(), m_axis_tvalid);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== '0)
      $display("FAIL async_reset: got tvalid %b tready %b tdata %0d expected 0 0 0", m_axis_tvalid, s_axis_tready, m_axis_tdata);
    else pass_cnt++;
    sb_q.delete();
    model_val     = 0;
    m_axis_tready = 1'b1;
    tick(2);
    #2 rst_n = 1'b1;
    tick(30);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    delivered = 0;
    model_val = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_valid_gaps();
    test_combined();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
